sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Two-requester arbiter sharing one synchronous single-port SRAM between the instruction bus and the data bus of the core.
- Sits between the core's two bus masters and a unified SRAM, in place of two independent bus-to-SRAM bridges.
- Sequences each access through a fixed issue/response FSM and returns read data with a one-cycle ack pulse.

Parameters:
- ADDR_W, 32, address width of requesters and SRAM.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-bus request; held with i_addr, i_we, i_wdata until i_ack.
- i_we  in  DATA_W/8  instruction byte write enables; 0 means read.
- i_addr  in  ADDR_W  instruction address.
- i_wdata  in  DATA_W  instruction write data.
- i_rdata  out  DATA_W  instruction read data; valid only while i_ack=1.
- i_ack  out  1  one-cycle completion pulse to the instruction bus.
- d_req  in  1  data-bus request; same rules as i_req.
- d_we  in  DATA_W/8  data byte write enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  data write data.
- d_rdata  out  DATA_W  data read data; valid only while d_ack=1.
- d_ack  out  1  one-cycle completion pulse to the data bus.
- sram_en  out  1  SRAM enable, registered.
- sram_we  out  DATA_W/8  SRAM byte write enables, registered.
- sram_addr  out  ADDR_W  SRAM address, registered.
- sram_wdata  out  DATA_W  SRAM write data, registered.
- sram_rdata  in  DATA_W  SRAM read data; valid the cycle after sram_en=1.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, grant=D, last=D. sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, i_ack=0, d_ack=0. Rdata outputs are don't-care while ack=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: arbitrate over i_req and d_req. If either is set, load grant and the granted master's we/addr/wdata into the sram_* registers, then go to ISSUE. Otherwise stay in IDLE with sram_en=0.
- ISSUE: sram_en=1 for exactly this one cycle; then go to RESP.
- RESP: sram_en=0.
  - The granted master's ack=1 and its rdata equals sram_rdata (passthrough). The other master's ack=0.
  - Writes also get an ack in RESP; rdata is don't-care for writes.
  - Re-arbitrate in the same cycle with the granted master's req masked. If the other master is requesting, load the sram_* registers and go to ISSUE; otherwise go to IDLE.
- Latency: req first seen in IDLE at cycle N -> sram_en at N+1 -> ack at N+2.
- Throughput: one access every 2 cycles when both masters request back-to-back.
- Fixed priority (default build): d_req wins over i_req when both are requesting in the same arbitration cycle.
- last: updated to the granted master on every grant; used only by the optional feature.
- Request withdrawn before ack: protocol violation. The access still completes and ack still pulses; the arbiter does not abort.
- Request fields are sampled only at grant; changes after grant have no effect on the current access.
- Reset mid-access: the SRAM access is abandoned immediately and no ack is issued. The requester re-issues after reset.
- The arbiter performs no address decode or width conversion; sram_addr equals the granted address bit-for-bit.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined: when both masters request in the same arbitration cycle, the master not equal to last wins. A single requester always wins regardless of last. This guarantees neither bus waits more than one foreign access.
- Undefined: fixed data-over-instruction priority as above. last is still maintained but ignored.

Test Plan:
- Single read: reset, then i_req=1, i_addr=0x1FC00000, i_we=0, with the SRAM model returning 0x3C1DBFC0 -> sram_en=1 with sram_addr=0x1FC00000 at N+1; i_ack=1 with i_rdata=0x3C1DBFC0 at N+2; d_ack stays 0.
- Byte write: d_req=1, d_we=4'b0010, d_addr=0x80001004, d_wdata=0x0000AB00 -> at N+1 sram_we=4'b0010 and sram_wdata=0x0000AB00; d_ack at N+2; memory changes only byte 1.
- Simultaneous requests, default build: i_req and d_req both held high -> order is D, I, D, I... with acks every 2 cycles. Data acks at N+2 and N+6 (each access cycle re-requested); instruction ack at N+4.
- Simultaneous requests with SRAM_ARB_ROUND_ROBIN_EN and last=D -> instruction is granted first, i_ack at N+2, then d_ack at N+4.
- Back-to-back from RESP: d access in flight while i_req rises during ISSUE -> i access goes to ISSUE the cycle after d_ack with no IDLE cycle between.
- Reset mid-access: resetn=0 during ISSUE -> sram_en, i_ack and d_ack go to 0 immediately with no ack afterwards. After release, the held request completes with 2-cycle latency.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// ============================================================================
// Module      : sram_bus_arbiter
// Description : Shares one synchronous single-port SRAM between the core's
//               instruction and data buses through an IDLE/ISSUE/RESP
//               sequence.
//               Optional macro SRAM_ARB_ROUND_ROBIN_EN replaces the fixed
//               data-over-instruction priority with alternating priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  i_req,
    input  logic [DATA_W/8-1:0]   i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_ack,

    input  logic                  d_req,
    input  logic [DATA_W/8-1:0]   d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,

    output logic                  sram_en,
    output logic [DATA_W/8-1:0]   sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata
);

    localparam logic c_GNT_I = 1'b0;
    localparam logic c_GNT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_grant;
    logic   r_last;
    logic   w_req_i;
    logic   w_req_d;
    logic   w_load;
    logic   w_prefer_i;
    logic   w_sel;

    // Arbitration happens in IDLE and again in RESP, where the master just
    // served is masked so the other one can be issued without an IDLE gap.
    always_comb begin
        w_state_nxt = r_state;
        w_req_i     = 1'b0;
        w_req_d     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_i = i_req;
                w_req_d = d_req;
            end
            ST_ISSUE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_req_i     = i_req && (r_grant != c_GNT_I);
                w_req_d     = d_req && (r_grant != c_GNT_D);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_load = w_req_i || w_req_d;
        if (w_load) begin
            w_state_nxt = ST_ISSUE;
        end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
        w_prefer_i = (r_last == c_GNT_D);
`else
        // last is kept up to date but has no say under fixed priority
        w_prefer_i = 1'b0 & r_last;
`endif
        w_sel = w_req_d && !(w_req_i && w_prefer_i);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_grant    <= c_GNT_D;
            r_last     <= c_GNT_D;
            sram_en    <= 1'b0;
            sram_we    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            sram_en <= w_load;
            if (w_load) begin
                r_grant    <= w_sel;
                r_last     <= w_sel;
                sram_we    <= w_sel ? d_we    : i_we;
                sram_addr  <= w_sel ? d_addr  : i_addr;
                sram_wdata <= w_sel ? d_wdata : i_wdata;
            end
        end
    end

    assign i_ack   = (r_state == ST_RESP) && (r_grant == c_GNT_I);
    assign d_ack   = (r_state == ST_RESP) && (r_grant == c_GNT_D);
    assign i_rdata = sram_rdata;
    assign d_rdata = sram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
// ============================================================================
// Module      : tb_sram_bus_arbiter
// Description : Scoreboard bench for sram_bus_arbiter with a behavioural SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, d_req;
    logic [3:0]  i_we, d_we;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ack, d_ack;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; } iss_t;
    typedef struct { int cyc; logic rd; logic [31:0] data; } ack_t;

    iss_t iss_q[$];
    ack_t iq[$];
    ack_t dq[$];

    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural synchronous SRAM: read data appears the cycle after sram_en
    always @(posedge clk) begin : sram_model
        logic [31:0] word;
        if (sram_en) begin
            word = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : dflt(sram_addr);
            sram_rdata <= word;
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) word[8*b +: 8] = sram_wdata[8*b +: 8];
            sram_mem[sram_addr] = word;
        end
    end

    // Monitor: every SRAM issue and every ack must match the next expectation
    always @(negedge clk) begin : monitor
        iss_t e;
        ack_t k;
        if (sram_en) begin
            if (iss_q.size() == 0) check("sram_en_unexpected", 1, 0);
            else begin
                e = iss_q.pop_front();
                check("issue_cycle", cyc, e.cyc);
                check("sram_addr", sram_addr, e.addr);
                check("sram_we", sram_we, e.we);
                check("sram_wdata", sram_wdata, e.wdata);
            end
        end
        if (i_ack || d_ack) check("ack_exclusive", i_ack & d_ack, 0);
        if (i_ack) begin
            if (iq.size() == 0) check("i_ack_unexpected", 1, 0);
            else begin
                k = iq.pop_front();
                check("i_ack_cycle", cyc, k.cyc);
                if (k.rd) check("i_rdata", i_rdata, k.data);
            end
        end
        if (d_ack) begin
            if (dq.size() == 0) check("d_ack_unexpected", 1, 0);
            else begin
                k = dq.pop_front();
                check("d_ack_cycle", cyc, k.cyc);
                if (k.rd) check("d_rdata", d_rdata, k.data);
            end
        end
    end

    // Push the expected issue and ack; m=1 selects the data bus
    task automatic sb_push(input logic m, input logic [3:0] we, input logic [31:0] a,
                           input logic [31:0] wd, input int c_iss);
        iss_t e;
        ack_t k;
        logic [31:0] word;
        e.cyc = c_iss; e.addr = a; e.we = we; e.wdata = wd;
        iss_q.push_back(e);
        word = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        k.cyc = c_iss + 1; k.rd = (we == 4'b0000); k.data = word;
        for (int b = 0; b < 4; b++)
            if (we[b]) word[8*b +: 8] = wd[8*b +: 8];
        ref_mem[a] = word;
        if (m) dq.push_back(k);
        else   iq.push_back(k);
    endtask

    task automatic drive(input logic m, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
        if (m) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
        else   begin i_req = 1'b1; i_we = we; i_addr = a; i_wdata = wd; end
    endtask

    task automatic release_req(input logic m);
        if (m) d_req = 1'b0;
        else   i_req = 1'b0;
    endtask

    task automatic wait_ack(input logic m);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = m ? d_ack : i_ack;
        end
        if (!got) check("ack_timeout", 0, 1);
        release_req(m);
    endtask

    task automatic run_one(input logic m, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        n = cyc;
        drive(m, we, a, wd);
        sb_push(m, we, a, wd, n + 1);
        wait_ack(m);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (iss_q.size() + iq.size() + dq.size()) != 0; k++) begin
            @(negedge clk);
            #1;
        end
        check("drain_pending", iss_q.size() + iq.size() + dq.size(), 0);
        iss_q.delete(); iq.delete(); dq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        iss_t e;
        resetn = 1'b0;
        i_req = 1'b0; i_we = '0; i_addr = '0; i_wdata = '0;
        d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
        sram_mem[32'h1FC0_0000] = 32'h3C1D_BFC0;
        ref_mem[32'h1FC0_0000]  = 32'h3C1D_BFC0;

        repeat (2) @(negedge clk);
        check("rst_sram_en", sram_en, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_wdata", sram_wdata, 0);
        check("rst_i_ack", i_ack, 0);
        check("rst_d_ack", d_ack, 0);
        resetn = 1'b1;

        // single instruction read, then byte write and read-back on the data bus
        run_one(1'b0, 4'b0000, 32'h1FC0_0000, 32'h0);
        run_one(1'b1, 4'b0010, 32'h8000_1004, 32'h0000_AB00);
        run_one(1'b1, 4'b0000, 32'h8000_1004, 32'hDEAD_BEEF);
        drain();

        // simultaneous requests; last grant was the data bus
        @(negedge clk);
        n = cyc;
        drive(1'b0, 4'b0000, 32'h0000_0100, 32'h0);
        drive(1'b1, 4'b0000, 32'h0000_0200, 32'h0);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        sb_push(1'b0, 4'b0000, 32'h0000_0100, 32'h0, n + 1);
        sb_push(1'b1, 4'b0000, 32'h0000_0200, 32'h0, n + 3);
        sb_push(1'b1, 4'b0000, 32'h0000_0300, 32'h0, n + 6);
        repeat (2) @(negedge clk); release_req(1'b0);
        repeat (2) @(negedge clk); drive(1'b1, 4'b0000, 32'h0000_0300, 32'h0);
        repeat (3) @(negedge clk); release_req(1'b1);
`else
        sb_push(1'b1, 4'b0000, 32'h0000_0200, 32'h0, n + 1);
        sb_push(1'b0, 4'b0000, 32'h0000_0100, 32'h0, n + 3);
        sb_push(1'b1, 4'b0000, 32'h0000_0300, 32'h0, n + 5);
        repeat (2) @(negedge clk); drive(1'b1, 4'b0000, 32'h0000_0300, 32'h0);
        repeat (2) @(negedge clk); release_req(1'b0);
        repeat (2) @(negedge clk); release_req(1'b1);
`endif
        drain();

        // instruction request rising during a data ISSUE goes straight from RESP
        @(negedge clk);
        n = cyc;
        drive(1'b1, 4'b0000, 32'h0000_0400, 32'h0);
        sb_push(1'b1, 4'b0000, 32'h0000_0400, 32'h0, n + 1);
        sb_push(1'b0, 4'b1111, 32'h0000_0500, 32'h0000_CAFE, n + 3);
        @(negedge clk); drive(1'b0, 4'b1111, 32'h0000_0500, 32'h0000_CAFE);
        @(negedge clk); release_req(1'b1);
        repeat (2) @(negedge clk); release_req(1'b0);
        drain();
        run_one(1'b1, 4'b0000, 32'h0000_0500, 32'h0);

        // reset during ISSUE abandons the access; the held request then completes
        @(negedge clk);
        n = cyc;
        drive(1'b0, 4'b0000, 32'h1FC0_0000, 32'h0);
        e.cyc = n + 1; e.addr = 32'h1FC0_0000; e.we = 4'b0000; e.wdata = 32'h0;
        iss_q.push_back(e);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst_sram_en", sram_en, 0);
        check("midrst_i_ack", i_ack, 0);
        check("midrst_d_ack", d_ack, 0);
        repeat (2) @(negedge clk);
        n = cyc;
        resetn = 1'b1;
        sb_push(1'b0, 4'b0000, 32'h1FC0_0000, 32'h0, n + 1);
        wait_ack(1'b0);
        drain();

        // short mixed random traffic over a small address window
        for (int k = 0; k < 8; k++) begin
            logic        m;
            logic [3:0]  we;
            logic [31:0] a;
            m  = 1'($urandom_range(0, 1));
            we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            a  = 32'h0000_2000 + 32'($urandom_range(0, 3)) * 32'd4;
            run_one(m, we, a, $urandom);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
